pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline.
- Generates per-register enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable, from three sources: load-use hazard detection, EX-stage branch resolution, and a data-memory ready handshake.
- Contains a memory-wait FSM with timeout, and saturating stall/flush performance counters.
- Sits beside the hazard/forwarding logic; drives the enable/flush pins of every pipeline register.

Parameters:
- TIMEOUT, 255, max consecutive MEM_WAIT cycles before entering ERROR (1..2^16-1).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- if_id_rs  in  5  rs field of the instruction in ID.
- if_id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw).
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rt  in  5  destination (rt) of the instruction in EX.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- ex_mem_memread  in  1  MEM-stage load.
- ex_mem_memwrite  in  1  MEM-stage store.
- dmem_ready  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  memory access request.
- pc_en  out  1  PC update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  synchronous bubble insert (flush wins over enable in the register).
- mem_error  out  1  sticky timeout flag.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0.
- flush_count  out  CNT_W  count of taken-branch flushes.

Behaviour:
- Control outputs are combinational from inputs and state, so hazards act in the same cycle.
- State, mem_error and the counters are registered.
- Reset value of every output:
  - All enables 1, all flushes 0, dmem_req 0.
  - mem_error 0, counters 0, state RUN, wait counter 0.
- Signal definitions:
  - mem_op = ex_mem_memread | ex_mem_memwrite.
  - dmem_req = mem_op while in RUN or MEM_WAIT; 0 in ERROR.
  - mem_stall = dmem_req & !dmem_ready.
  - load_use = id_ex_memread & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (id_uses_rt & (id_ex_rt == if_id_rt))).
- Priority, highest first:
  1. ERROR or mem_stall: all enables 0, no flush except mem_wb_flush=1, so no duplicate WB.
     - Branch and load-use are ignored; the frozen EX instruction re-presents them next cycle.
  2. ex_branch_taken: pc_en=1 (loads target), if_id_flush=1, id_ex_flush=1, all other enables 1.
     - Any simultaneous load_use is discarded, since the stalled ID instruction is squashed anyway.
  3. load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
     - Exactly 1-cycle bubble per load-use.
  4. Otherwise: all enables 1, no flushes.
- FSM:
  - RUN -> MEM_WAIT when mem_stall.
  - MEM_WAIT: wait counter increments each cycle.
    - -> RUN on dmem_ready. The release cycle has full enables per priorities 2-4.
    - -> ERROR when the wait counter reaches TIMEOUT with dmem_ready still 0.
  - A request granted in the same cycle it is raised (dmem_ready=1) never leaves RUN and costs 0 stall cycles.
  - Wait counter clears on entry to RUN.
  - ERROR: mem_error=1, pipeline frozen, dmem_req=0; exit only via reset.
- Counters (both saturate at all-ones, never wrap):
  - stall_cycles increments every cycle pc_en=0, including ERROR cycles.
  - flush_count increments on each cycle where priority 2 is the active rule.
- Reset mid-MEM_WAIT: immediate return to RUN, counters cleared, request dropped.

Decomposition:
- Shared pipeline package holds:
  - The FSM state enum (RUN, MEM_WAIT, ERROR).
  - The register-number width constant (5).
  - The zero-register constant.
- One natural sub-module, sat_counter (parameter W, inc input, async reset), instantiated twice for the counters.
- Hazard and priority logic stay inline.

Test Plan:
- Load-use: lw $2 in EX (id_ex_memread=1, id_ex_rt=2), ID rs=2 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1.
- Zero register and unused rt: id_ex_rt=0 matching rs=0 -> no stall; rt match with id_uses_rt=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 and load_use=1 in the same cycle -> pc_en=1, if_id_flush=1, id_ex_flush=1; flush_count=1, stall_cycles unchanged.
- Memory wait: sw in MEM with dmem_ready low for 3 cycles -> all enables 0 and mem_wb_flush=1 for 3 cycles, state MEM_WAIT, stall_cycles=3.
  - Ready on cycle 4 -> RUN with full enables.
- Timeout: TIMEOUT=4, dmem_ready held 0 -> ERROR after 4 wait cycles; mem_error=1, dmem_req=0, pipeline frozen.
  - Reset clears everything to reset values.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cycles sticks at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register-number width, zero register and the
// memory-wait FSM state encoding used by the hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam int REG_W  = 5;
   localparam int WAIT_W = 16;

   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_ERROR    = 2'd2;

   typedef enum logic [1:0] {
      RUN      = ST_RUN,
      MEM_WAIT = ST_MEM_WAIT,
      ERROR    = ST_ERROR
   } state_e;

   // $zero never carries a real dependency, so it can never cause a hazard.
   function automatic logic reg_hit(input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] src);
      return (dst != ZERO_REG) && (dst == src);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard/sequencing
// controller (slave): hazard sources in, register enables/flushes out.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   import pipe_hazard_ctrl_pkg::*;

   logic [REG_W-1:0] if_id_rs;
   logic [REG_W-1:0] if_id_rt;
   logic             id_uses_rt;
   logic             id_ex_memread;
   logic [REG_W-1:0] id_ex_rt;
   logic             ex_branch_taken;
   logic             ex_mem_memread;
   logic             ex_mem_memwrite;
   logic             dmem_ready;

   logic             dmem_req;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             mem_wb_flush;
   logic             mem_error;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output if_id_rs, if_id_rt, id_uses_rt, id_ex_memread, id_ex_rt,
             ex_branch_taken, ex_mem_memread, ex_mem_memwrite, dmem_ready,
      input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, mem_wb_flush, mem_error,
             stall_cycles, flush_count
   );

   modport slave (
      input  if_id_rs, if_id_rt, id_uses_rt, id_ex_memread, id_ex_rt,
             ex_branch_taken, ex_mem_memread, ex_mem_memwrite, dmem_ready,
      output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, mem_wb_flush, mem_error,
             stall_cycles, flush_count
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_r;

   // Count qualifying cycles, holding once the maximum is reached.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= {W{1'b0}};
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: resolves memory wait, taken branch and
// load-use hazards into per-register enables/flushes, with a wait timeout.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);

   state_e              state_r;
   state_e              state_nxt_s;
   logic [WAIT_W-1:0]   wait_cnt_r;
   logic [WAIT_W-1:0]   wait_cnt_nxt_s;
   logic [WAIT_W:0]     wait_inc_s;
   logic                mem_error_r;

   logic                mem_op_s;
   logic                dmem_req_s;
   logic                mem_stall_s;
   logic                load_use_s;
   logic                freeze_s;
   logic                branch_s;

   logic                req_out_s;
   logic                pc_en_s;
   logic                if_id_en_s;
   logic                id_ex_en_s;
   logic                ex_mem_en_s;
   logic                mem_wb_en_s;
   logic                if_id_flush_s;
   logic                id_ex_flush_s;
   logic                mem_wb_flush_s;
   logic [CNT_W-1:0]    stall_cnt_s;
   logic [CNT_W-1:0]    flush_cnt_s;

   assign mem_op_s    = bus.ex_mem_memread | bus.ex_mem_memwrite;
   assign dmem_req_s  = mem_op_s & (state_r != ERROR);
   assign mem_stall_s = dmem_req_s & ~bus.dmem_ready;
   assign load_use_s  = bus.id_ex_memread &
                        (reg_hit(bus.id_ex_rt, bus.if_id_rs) |
                         (bus.id_uses_rt & reg_hit(bus.id_ex_rt, bus.if_id_rt)));
   assign freeze_s    = (state_r == ERROR) | mem_stall_s;
   assign wait_inc_s  = {1'b0, wait_cnt_r} + (WAIT_W+1)'(1);

   // Priority resolution: freeze > taken branch > load-use > free running.
   always_comb begin
      req_out_s      = 1'b0;
      pc_en_s        = 1'b1;
      if_id_en_s     = 1'b1;
      id_ex_en_s     = 1'b1;
      ex_mem_en_s    = 1'b1;
      mem_wb_en_s    = 1'b1;
      if_id_flush_s  = 1'b0;
      id_ex_flush_s  = 1'b0;
      mem_wb_flush_s = 1'b0;
      branch_s       = 1'b0;
      if (reset) begin
         req_out_s = 1'b0;
      end else begin
         req_out_s = dmem_req_s;
         if (freeze_s) begin
            // Bubble into WB so the frozen MEM instruction is not retired twice.
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            id_ex_en_s     = 1'b0;
            ex_mem_en_s    = 1'b0;
            mem_wb_en_s    = 1'b0;
            mem_wb_flush_s = 1'b1;
         end else if (bus.ex_branch_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            branch_s      = 1'b1;
         end else if (load_use_s) begin
            pc_en_s       = 1'b0;
            if_id_en_s    = 1'b0;
            id_ex_flush_s = 1'b1;
         end else begin
            branch_s = 1'b0;
         end
      end
   end

   // Memory-wait FSM next state and wait-cycle counting.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      case (state_r)
         RUN: begin
            if (mem_stall_s) begin
               state_nxt_s = MEM_WAIT;
            end else begin
               state_nxt_s = RUN;
            end
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
         end
         MEM_WAIT: begin
            if (!mem_stall_s) begin
               state_nxt_s    = RUN;
               wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end else if (wait_inc_s >= (WAIT_W+1)'(TIMEOUT)) begin
               state_nxt_s    = ERROR;
               wait_cnt_nxt_s = wait_inc_s[WAIT_W-1:0];
            end else begin
               wait_cnt_nxt_s = wait_inc_s[WAIT_W-1:0];
            end
         end
         ERROR: begin
            state_nxt_s = ERROR;
         end
         default: begin
            state_nxt_s    = RUN;
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
         end
      endcase
   end

   // FSM state, wait counter and sticky error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= RUN;
         wait_cnt_r  <= {WAIT_W{1'b0}};
         mem_error_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         wait_cnt_r  <= wait_cnt_nxt_s;
         mem_error_r <= mem_error_r | (state_nxt_s == ERROR);
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (~pc_en_s),
      .count (stall_cnt_s)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (branch_s),
      .count (flush_cnt_s)
   );

   assign bus.dmem_req     = req_out_s;
   assign bus.pc_en        = pc_en_s;
   assign bus.if_id_en     = if_id_en_s;
   assign bus.id_ex_en     = id_ex_en_s;
   assign bus.ex_mem_en    = ex_mem_en_s;
   assign bus.mem_wb_en    = mem_wb_en_s;
   assign bus.if_id_flush  = if_id_flush_s;
   assign bus.id_ex_flush  = id_ex_flush_s;
   assign bus.mem_wb_flush = mem_wb_flush_s;
   assign bus.mem_error    = mem_error_r;
   assign bus.stall_cycles = stall_cnt_s;
   assign bus.flush_count  = flush_cnt_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, hand-written multi-cycle
// sequences, then random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   // {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush}
   localparam logic [8:0] C_RUN     = 9'b0_1111_1000;
   localparam logic [8:0] C_REQ_RUN = 9'b1_1111_1000;
   localparam logic [8:0] C_LU      = 9'b0_0011_1010;
   localparam logic [8:0] C_REQ_LU  = 9'b1_0011_1010;
   localparam logic [8:0] C_BR      = 9'b0_1111_1110;
   localparam logic [8:0] C_REQ_BR  = 9'b1_1111_1110;
   localparam logic [8:0] C_FRZ     = 9'b1_0000_0001;
   localparam logic [8:0] C_ERR     = 9'b0_0000_0001;

   typedef struct {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       ex_rd;
      logic [4:0] ex_rt;
      logic       br;
      logic       mem_rd;
      logic       mem_wr;
      logic       ready;
   } in_t;

   typedef struct {
      in_t        in;
      logic [8:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   // behavioural model: 0 running, 1 waiting on memory, 2 dead
   int   m_mode, m_wait, m_stall, m_flush;
   bit   m_err;
   logic [8:0] last_ctrl;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t mk(input int rs, input int rt, input int uses, input int exrd,
                              input int exrt, input int br, input int mrd, input int mwr,
                              input int rdy, input int rst);
      in_t v;
      v.rs = 5'(rs);       v.rt = 5'(rt);       v.uses_rt = 1'(uses);
      v.ex_rd = 1'(exrd);  v.ex_rt = 5'(exrt);  v.br = 1'(br);
      v.mem_rd = 1'(mrd);  v.mem_wr = 1'(mwr);  v.ready = 1'(rdy);
      v.rst = 1'(rst);
      return v;
   endfunction

   function automatic vec_t mv(input in_t i, input logic [8:0] e);
      vec_t r;
      r.in = i;
      r.exp = e;
      return r;
   endfunction

   task automatic model_clear();
      m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
   endtask

   function automatic logic [8:0] model_ctrl(input in_t v);
      bit req, stall, lu;
      if (v.rst) return C_RUN;
      req   = (v.mem_rd || v.mem_wr) && (m_mode != 2);
      stall = req && !v.ready;
      lu    = v.ex_rd && (v.ex_rt != 0) &&
              ((v.ex_rt == v.rs) || (v.uses_rt && (v.ex_rt == v.rt)));
      if (m_mode == 2 || stall) return {req, 8'b0000_0001};
      if (v.br)                 return {req, 8'b1111_1110};
      if (lu)                   return {req, 8'b0011_1010};
      return {req, 8'b1111_1000};
   endfunction

   task automatic model_step(input in_t v, input logic [8:0] c);
      bit stall;
      stall = c[8] && !v.ready;
      if (!c[7] && m_stall < CMAX) m_stall++;
      if (c[2] && m_flush < CMAX) m_flush++;
      if (m_mode == 0) begin
         if (stall) begin m_mode = 1; m_wait = 0; end
      end else if (m_mode == 1) begin
         if (!stall) m_mode = 0;
         else begin
            m_wait++;
            if (m_wait >= TIMEOUT) begin m_mode = 2; m_err = 1'b1; end
         end
      end
   endtask

   task automatic cycle(input in_t v);
      logic [8:0] expc;
      reset                = v.rst;
      bus.if_id_rs         = v.rs;
      bus.if_id_rt         = v.rt;
      bus.id_uses_rt       = v.uses_rt;
      bus.id_ex_memread    = v.ex_rd;
      bus.id_ex_rt         = v.ex_rt;
      bus.ex_branch_taken  = v.br;
      bus.ex_mem_memread   = v.mem_rd;
      bus.ex_mem_memwrite  = v.mem_wr;
      bus.dmem_ready       = v.ready;
      #2;
      if (v.rst) model_clear();
      expc = model_ctrl(v);
      last_ctrl = {bus.dmem_req, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                   bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
      check("ctrl", 32'(last_ctrl), 32'(expc));
      check("mem_error", 32'(bus.mem_error), 32'(m_err));
      check("stall_cycles", 32'(bus.stall_cycles), m_stall);
      check("flush_count", 32'(bus.flush_count), m_flush);
      @(posedge clk);
      if (!v.rst) model_step(v, expc);
      #1;
   endtask

   initial begin
      vec_t tbl[11];
      in_t  nop, rst, lu, brlu, sw0, sw1, v;

      nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      lu   = mk(2, 0, 0, 1, 2, 0, 0, 0, 0, 0);
      brlu = mk(2, 0, 0, 1, 2, 1, 0, 0, 0, 0);
      sw0  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      sw1  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

      tbl[0]  = mv(nop, C_RUN);
      tbl[1]  = mv(mk(2, 7, 0, 1, 2, 0, 0, 0, 0, 0), C_LU);
      tbl[2]  = mv(mk(5, 3, 1, 1, 3, 0, 0, 0, 0, 0), C_LU);
      tbl[3]  = mv(mk(5, 3, 0, 1, 3, 0, 0, 0, 0, 0), C_RUN);
      tbl[4]  = mv(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0), C_RUN);
      tbl[5]  = mv(mk(4, 4, 1, 0, 4, 0, 0, 0, 0, 0), C_RUN);
      tbl[6]  = mv(mk(1, 1, 0, 0, 9, 1, 0, 0, 0, 0), C_BR);
      tbl[7]  = mv(brlu, C_BR);
      tbl[8]  = mv(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0), C_REQ_RUN);
      tbl[9]  = mv(mk(6, 0, 0, 1, 6, 0, 0, 1, 1, 0), C_REQ_LU);
      tbl[10] = mv(mk(6, 0, 0, 1, 6, 1, 1, 0, 1, 0), C_REQ_BR);

      model_clear();
      bus.if_id_rs = 5'd0; bus.if_id_rt = 5'd0; bus.id_uses_rt = 1'b0;
      bus.id_ex_memread = 1'b0; bus.id_ex_rt = 5'd0; bus.ex_branch_taken = 1'b0;
      bus.ex_mem_memread = 1'b0; bus.ex_mem_memwrite = 1'b0; bus.dmem_ready = 1'b0;
      @(posedge clk);
      #1;

      // reset values
      cycle(rst);
      check("rst_ctrl", 32'(last_ctrl), 32'(C_RUN));
      check("rst_err", 32'(bus.mem_error), 32'd0);
      check("rst_stall", 32'(bus.stall_cycles), 32'd0);

      // single-cycle priority table
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].in);
         check($sformatf("vec%0d", i), 32'(last_ctrl), 32'(tbl[i].exp));
      end

      // load-use: exactly one bubble
      cycle(rst);
      cycle(lu);
      check("lu_ctrl", 32'(last_ctrl), 32'(C_LU));
      check("lu_stall", 32'(bus.stall_cycles), 32'd1);
      cycle(nop);
      check("lu_after", 32'(last_ctrl), 32'(C_RUN));
      check("lu_stall2", 32'(bus.stall_cycles), 32'd1);

      // branch beats load-use
      cycle(rst);
      cycle(brlu);
      check("brlu_ctrl", 32'(last_ctrl), 32'(C_BR));
      check("brlu_flush", 32'(bus.flush_count), 32'd1);
      check("brlu_stall", 32'(bus.stall_cycles), 32'd0);

      // memory wait 3 cycles then release
      cycle(rst);
      for (int i = 0; i < 3; i++) begin
         cycle(sw0);
         check($sformatf("mw_frz%0d", i), 32'(last_ctrl), 32'(C_FRZ));
      end
      check("mw_stall", 32'(bus.stall_cycles), 32'd3);
      cycle(sw1);
      check("mw_release", 32'(last_ctrl), 32'(C_REQ_RUN));
      check("mw_stall2", 32'(bus.stall_cycles), 32'd3);
      cycle(nop);
      check("mw_run", 32'(last_ctrl), 32'(C_RUN));

      // timeout into ERROR, then reset recovery
      cycle(rst);
      for (int i = 0; i < 4; i++) cycle(sw0);
      check("to_noerr", 32'(bus.mem_error), 32'd0);
      cycle(sw0);
      check("to_err", 32'(bus.mem_error), 32'd1);
      cycle(sw1);
      check("to_frozen", 32'(last_ctrl), 32'(C_ERR));
      cycle(brlu);
      check("to_frozen2", 32'(last_ctrl), 32'(C_ERR));
      check("to_stall", 32'(bus.stall_cycles), 32'd7);
      cycle(rst);
      check("to_rst_ctrl", 32'(last_ctrl), 32'(C_RUN));
      check("to_rst_err", 32'(bus.mem_error), 32'd0);
      check("to_rst_stall", 32'(bus.stall_cycles), 32'd0);

      // reset in the middle of a memory wait
      cycle(sw0);
      cycle(sw0);
      v = sw0;
      v.rst = 1'b1;
      cycle(v);
      check("mwrst_req", 32'(last_ctrl), 32'(C_RUN));
      cycle(sw1);
      check("mwrst_grant", 32'(last_ctrl), 32'(C_REQ_RUN));
      check("mwrst_stall", 32'(bus.stall_cycles), 32'd0);

      // counter saturation
      cycle(rst);
      for (int i = 0; i < 20; i++) cycle(lu);
      check("sat_stall", 32'(bus.stall_cycles), 32'd15);

      // random stimulus against the model
      for (int n = 0; n < 3000; n++) begin
         v = mk($urandom_range(7), $urandom_range(7), $urandom_range(1), $urandom_range(1),
                $urandom_range(7), ($urandom_range(5) == 0) ? 1 : 0,
                ($urandom_range(2) == 0) ? 1 : 0, ($urandom_range(2) == 0) ? 1 : 0,
                ($urandom_range(2) == 0) ? 1 : 0, ($urandom_range(49) == 0) ? 1 : 0);
         cycle(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
